// File: rtl/display_timing_pkg.sv
// Shared timing constants, raster arithmetic helpers and the control bundle type for the display timing generator.
// Latency: none (package only).
// Backpressure: none (package only).
package display_timing_pkg;

    // 640x480@60 defaults
    localparam int DEF_H_RES  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_CW     = 12;

    // Total pixels per line / lines per frame, including blanking.
    function automatic int raster_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    // First counter value inside the sync pulse.
    function automatic int sync_start(input int res, input int fp);
        return res + fp;
    endfunction

    // First counter value after the sync pulse.
    function automatic int sync_end(input int res, input int fp, input int sync);
        return res + fp + sync;
    endfunction

    // Raster control bundle; all fields are active-high, polarity is applied at the output.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/timing_delay_line.sv
// Fixed-depth shift register used to realign raster control with fetched pixel data.
// Latency: DEPTH clocks; DEPTH=0 is a plain wire.
// Backpressure: none, shifts every clock.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, all stages load RST_VAL
//   i_dat   : WIDTH-bit input
//   o_dat   : WIDTH-bit output, i_dat delayed DEPTH clocks
module timing_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_dat = i_dat;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign o_dat = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator: pixel/line counters, fetch coordinates to a fixed-latency source, realigned DE/syncs/RGB for the TMDS encoder.
// Latency: o_sx/o_sy/o_req/o_frame/o_line follow the counters directly; o_de/o_hsync/o_vsync/o_data_*/o_ctrl_* lag them by PIX_LAT+1 clocks.
// Backpressure: none; the raster free-runs while enabled, i_en low parks it at the origin and drains the pipeline to idle.
//   i_clk, i_rst_n          : pixel clock, asynchronous active-low reset
//   i_en                    : run enable; the raster starts at (0,0) one clock after it is seen high
//   i_pix_r/g/b             : source pixel, valid PIX_LAT clocks after the matching o_req
//   o_sx, o_sy, o_req       : fetch coordinate and fetch valid (active area)
//   o_frame, o_line         : start-of-frame / start-of-line pulses, counter-aligned
//   o_de, o_hsync, o_vsync  : realigned raster control, syncs at H_POL/V_POL when asserted
//   o_data_ch0/1/2          : blue/green/red, zero outside display enable
//   o_ctrl_ch0/1/2          : TMDS control words, {vsync,hsync} on ch0, zero on ch1/ch2
module display_timing_gen
    import display_timing_pkg::*;
#(
    parameter int   H_RES   = DEF_H_RES,
    parameter int   H_FP    = DEF_H_FP,
    parameter int   H_SYNC  = DEF_H_SYNC,
    parameter int   H_BP    = DEF_H_BP,
    parameter int   V_RES   = DEF_V_RES,
    parameter int   V_FP    = DEF_V_FP,
    parameter int   V_SYNC  = DEF_V_SYNC,
    parameter int   V_BP    = DEF_V_BP,
    parameter logic H_POL   = 1'b0,
    parameter logic V_POL   = 1'b0,
    parameter int   PIX_LAT = 1,
    parameter int   CW      = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [7:0]    i_pix_r,
    input  logic [7:0]    i_pix_g,
    input  logic [7:0]    i_pix_b,
    output logic [CW-1:0] o_sx,
    output logic [CW-1:0] o_sy,
    output logic          o_req,
    output logic          o_frame,
    output logic          o_line,
    output logic          o_de,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic [7:0]    o_data_ch0,
    output logic [7:0]    o_data_ch1,
    output logic [7:0]    o_data_ch2,
    output logic [1:0]    o_ctrl_ch0,
    output logic [1:0]    o_ctrl_ch1,
    output logic [1:0]    o_ctrl_ch2
);

    localparam logic [CW-1:0] H_LAST   = CW'(raster_total(H_RES, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(raster_total(V_RES, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_RES);
    localparam logic [CW-1:0] V_ACT    = CW'(V_RES);
    localparam logic [CW-1:0] HS_START = CW'(sync_start(H_RES, H_FP));
    localparam logic [CW-1:0] HS_END   = CW'(sync_end(H_RES, H_FP, H_SYNC));
    localparam logic [CW-1:0] VS_START = CW'(sync_start(V_RES, V_FP));
    localparam logic [CW-1:0] VS_END   = CW'(sync_end(V_RES, V_FP, V_SYNC));

    logic          run_q;
    logic          enabled;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    ctrl_t         raw_ctrl;
    ctrl_t         dly_ctrl;
    logic          hs_lvl;
    logic          vs_lvl;

    // run_q keeps the raster parked through reset and for the first clock after
    // release, so the first enabled cycle is always the origin. i_en still
    // gates combinationally so a drop blanks the fetch side on the same clock.
    assign enabled = run_q & i_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= 1'b0;
            sx    <= '0;
            sy    <= '0;
        end else begin
            run_q <= i_en;
            if (!enabled) begin
                sx <= '0;
                sy <= '0;
            end else if (sx == H_LAST) begin
                sx <= '0;
                sy <= (sy == V_LAST) ? '0 : sy + CW'(1);
            end else begin
                sx <= sx + CW'(1);
            end
        end
    end

    assign o_sx    = sx;
    assign o_sy    = sy;
    assign o_req   = enabled && (sx < H_ACT) && (sy < V_ACT);
    assign o_frame = enabled && (sx == '0) && (sy == '0);
    assign o_line  = enabled && (sx == '0);

    // vs depends only on sy, so it naturally changes at the sx wrap.
    always_comb begin
        raw_ctrl    = CTRL_IDLE;
        raw_ctrl.de = o_req;
        raw_ctrl.hs = enabled && (sx >= HS_START) && (sx < HS_END);
        raw_ctrl.vs = enabled && (sy >= VS_START) && (sy < VS_END);
    end

    // Matches the source read latency so control lines up with i_pix_*.
    timing_delay_line #(
        .DEPTH   (PIX_LAT),
        .WIDTH   ($bits(ctrl_t)),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_dat   (raw_ctrl),
        .o_dat   (dly_ctrl)
    );

    assign hs_lvl = dly_ctrl.hs ? H_POL : ~H_POL;
    assign vs_lvl = dly_ctrl.vs ? V_POL : ~V_POL;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de       <= 1'b0;
            o_hsync    <= ~H_POL;
            o_vsync    <= ~V_POL;
            o_ctrl_ch0 <= {~V_POL, ~H_POL};
            o_data_ch0 <= '0;
            o_data_ch1 <= '0;
            o_data_ch2 <= '0;
        end else begin
            o_de       <= dly_ctrl.de;
            o_hsync    <= hs_lvl;
            o_vsync    <= vs_lvl;
            o_ctrl_ch0 <= {vs_lvl, hs_lvl};
            o_data_ch0 <= dly_ctrl.de ? i_pix_b : 8'd0;
            o_data_ch1 <= dly_ctrl.de ? i_pix_g : 8'd0;
            o_data_ch2 <= dly_ctrl.de ? i_pix_r : 8'd0;
        end
    end

    assign o_ctrl_ch1 = 2'b00;
    assign o_ctrl_ch2 = 2'b00;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench for display_timing_gen on a reduced raster (64x23 total, 48x16 active) with PIX_LAT 0, 1 and 4 side by side.
// Latency: checks alignment at PIX_LAT+1 clocks for each instance.
// Backpressure: exercises i_en drop/re-enable and asynchronous reset mid-line.
module tb_display_timing_gen;

    // Reduced raster: H 48+4+6+6=64, V 16+2+2+3=23, frame = 1472 clocks.
    // hsync counter range 52..57, vsync line range 18..19.
    localparam int FRAME = 1472;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- PIX_LAT = 0 instance ----------------
    logic [11:0] d0_sx, d0_sy;
    logic        d0_req, d0_frame, d0_line, d0_de, d0_hsync, d0_vsync;
    logic [7:0]  d0_r, d0_g, d0_b, d0_ch0, d0_ch1, d0_ch2;
    logic [1:0]  d0_c0, d0_c1, d0_c2;

    assign d0_r = d0_sx[7:0];
    assign d0_g = d0_sy[7:0];
    assign d0_b = 8'hA5;

    display_timing_gen #(
        .H_RES(48), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_RES(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(0), .CW(12)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_pix_r(d0_r), .i_pix_g(d0_g), .i_pix_b(d0_b),
        .o_sx(d0_sx), .o_sy(d0_sy), .o_req(d0_req), .o_frame(d0_frame), .o_line(d0_line),
        .o_de(d0_de), .o_hsync(d0_hsync), .o_vsync(d0_vsync),
        .o_data_ch0(d0_ch0), .o_data_ch1(d0_ch1), .o_data_ch2(d0_ch2),
        .o_ctrl_ch0(d0_c0), .o_ctrl_ch1(d0_c1), .o_ctrl_ch2(d0_c2)
    );

    // ---------------- PIX_LAT = 1 instance (main) ----------------
    logic [11:0] d1_sx, d1_sy;
    logic        d1_req, d1_frame, d1_line, d1_de, d1_hsync, d1_vsync;
    logic [7:0]  d1_r, d1_g, d1_b, d1_ch0, d1_ch1, d1_ch2;
    logic [1:0]  d1_c0, d1_c1, d1_c2;

    always @(posedge clk) begin
        d1_r <= d1_sx[7:0];
        d1_g <= d1_sy[7:0];
    end
    assign d1_b = 8'hA5;

    display_timing_gen #(
        .H_RES(48), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_RES(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(1), .CW(12)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_pix_r(d1_r), .i_pix_g(d1_g), .i_pix_b(d1_b),
        .o_sx(d1_sx), .o_sy(d1_sy), .o_req(d1_req), .o_frame(d1_frame), .o_line(d1_line),
        .o_de(d1_de), .o_hsync(d1_hsync), .o_vsync(d1_vsync),
        .o_data_ch0(d1_ch0), .o_data_ch1(d1_ch1), .o_data_ch2(d1_ch2),
        .o_ctrl_ch0(d1_c0), .o_ctrl_ch1(d1_c1), .o_ctrl_ch2(d1_c2)
    );

    // ---------------- PIX_LAT = 4 instance ----------------
    logic [11:0] d4_sx, d4_sy;
    logic        d4_req, d4_frame, d4_line, d4_de, d4_hsync, d4_vsync;
    logic [7:0]  d4_r, d4_g, d4_b, d4_ch0, d4_ch1, d4_ch2;
    logic [1:0]  d4_c0, d4_c1, d4_c2;
    logic [15:0] p4 [4];

    always @(posedge clk) begin
        p4[0] <= {d4_sx[7:0], d4_sy[7:0]};
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign d4_r = p4[3][15:8];
    assign d4_g = p4[3][7:0];
    assign d4_b = 8'hA5;

    display_timing_gen #(
        .H_RES(48), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_RES(16), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(4), .CW(12)
    ) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_pix_r(d4_r), .i_pix_g(d4_g), .i_pix_b(d4_b),
        .o_sx(d4_sx), .o_sy(d4_sy), .o_req(d4_req), .o_frame(d4_frame), .o_line(d4_line),
        .o_de(d4_de), .o_hsync(d4_hsync), .o_vsync(d4_vsync),
        .o_data_ch0(d4_ch0), .o_data_ch1(d4_ch1), .o_data_ch2(d4_ch2),
        .o_ctrl_ch0(d4_c0), .o_ctrl_ch1(d4_c1), .o_ctrl_ch2(d4_c2)
    );

    // ---------------- per-clock monitor ----------------
    logic        win = 1'b0;
    int          de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fr_cnt = 0;
    int          bad_pix = 0, bad_ctrl = 0, bad_blank = 0;
    logic [16:0] hist0, hist1;

    always begin
        @(negedge clk);
        #1;
        if (d0_c0 !== {d0_vsync, d0_hsync} || d0_c1 !== 2'b00 || d0_c2 !== 2'b00 ||
            d1_c0 !== {d1_vsync, d1_hsync} || d1_c1 !== 2'b00 || d1_c2 !== 2'b00 ||
            d4_c0 !== {d4_vsync, d4_hsync} || d4_c1 !== 2'b00 || d4_c2 !== 2'b00)
            bad_ctrl <= bad_ctrl + 1;
        if ((!d0_de && {d0_ch2, d0_ch1, d0_ch0} !== 24'h0) ||
            (!d1_de && {d1_ch2, d1_ch1, d1_ch0} !== 24'h0) ||
            (!d4_de && {d4_ch2, d4_ch1, d4_ch0} !== 24'h0))
            bad_blank <= bad_blank + 1;
        if (win) begin
            if (d1_de)    de_cnt <= de_cnt + 1;
            if (!d1_hsync) hs_cnt <= hs_cnt + 1;
            if (!d1_vsync) vs_cnt <= vs_cnt + 1;
            if (d1_frame) fr_cnt <= fr_cnt + 1;
            // output at this sample reflects the fetch made two samples ago
            if (d1_de !== hist1[16] ||
                (d1_de && {d1_ch2, d1_ch1, d1_ch0} !== {hist1[15:0], 8'hA5}))
                bad_pix <= bad_pix + 1;
        end
        hist1 <= hist0;
        hist0 <= {d1_req, d1_sx[7:0], d1_sy[7:0]};
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        step(3);
        chk("rst_sx",    d1_sx, 0);
        chk("rst_req",   d1_req, 0);
        chk("rst_frame", d1_frame, 0);
        chk("rst_de",    d1_de, 0);
        chk("rst_hsync", d1_hsync, 1);
        chk("rst_vsync", d1_vsync, 1);
        chk("rst_ctrl0", d1_c0, 2'b11);
        chk("rst_data",  {d1_ch2, d1_ch1, d1_ch0}, 0);

        rst_n = 1'b1;
        step(1);                                   // r=0: first enabled clock
        win = 1'b1;
        chk("r0_frame", d1_frame, 1);
        chk("r0_line",  d1_line, 1);
        chk("r0_req",   d1_req, 1);
        chk("r0_sxsy",  {d1_sx, d1_sy}, 0);
        chk("r0_de",    d1_de, 0);
        chk("r0_hsync", d1_hsync, 1);
        chk("r0_vsync", d1_vsync, 1);
        step(1);                                   // r=1
        chk("r1_d0_de",  d0_de, 1);
        chk("r1_d0_pix", {d0_ch2, d0_ch1, d0_ch0}, 24'h0000A5);
        chk("r1_d1_de",  d1_de, 0);
        step(1);                                   // r=2
        chk("r2_d1_de",  d1_de, 1);
        chk("r2_d4_de",  d4_de, 0);
        step(3);                                   // r=5
        chk("r5_d4_de",  d4_de, 1);
        step(44);                                  // r=49: last active pixel
        chk("r49_de",    d1_de, 1);
        step(1);
        chk("r50_de",    d1_de, 0);
        step(3);
        chk("r53_hsync", d1_hsync, 1);
        step(1);
        chk("r54_hsync", d1_hsync, 0);
        step(5);
        chk("r59_hsync", d1_hsync, 0);
        step(1);
        chk("r60_hsync", d1_hsync, 1);
        step(746);                                 // r=806
        chk("px_lat0",   {d0_de, d0_ch2, d0_ch1, d0_ch0}, {1'b1, 24'h250CA5});
        step(1);                                   // r=807
        chk("px_lat1",   {d1_de, d1_ch2, d1_ch1, d1_ch0}, {1'b1, 24'h250CA5});
        step(3);                                   // r=810
        chk("px_lat4",   {d4_de, d4_ch2, d4_ch1, d4_ch0}, {1'b1, 24'h250CA5});
        step(343);                                 // r=1153
        chk("r1153_vs",  d1_vsync, 1);
        step(1);
        chk("r1154_vs",  d1_vsync, 0);
        step(127);
        chk("r1281_vs",  d1_vsync, 0);
        step(1);
        chk("r1282_vs",  d1_vsync, 1);
        step(190);                                 // r=1472: next frame
        win = 1'b0;
        chk("f2_frame",  d1_frame, 1);
        chk("f2_sxsy",   {d1_sx, d1_sy}, 0);

        // enable drop at (30,10)
        step(670);
        chk("drop_sxsy", {d1_sx, d1_sy}, {12'd30, 12'd10});
        chk("drop_pix",  {d1_de, d1_ch2, d1_ch1, d1_ch0}, {1'b1, 24'h1C0AA5});
        en = 1'b0;
        #1;
        chk("drop_req",  d1_req, 0);
        step(1);                                   // s=1
        chk("s1_sxsy",   {d1_sx, d1_sy}, 0);
        chk("s1_frame",  {d1_frame, d1_line, d1_req}, 0);
        chk("s1_d0_de",  d0_de, 0);
        chk("s1_d1_de",  d1_de, 1);
        step(1);                                   // s=2
        chk("s2_d1_idle", {d1_de, d1_hsync, d1_vsync, d1_ch2, d1_ch1, d1_ch0}, {3'b011, 24'h0});
        step(2);                                   // s=4
        chk("s4_d4_de",  d4_de, 1);
        step(1);                                   // s=5
        chk("s5_d4_de",  d4_de, 0);
        en = 1'b1;
        #1;
        chk("s5_frame",  d1_frame, 0);
        step(1);                                   // s=6: restart
        chk("re_frame",  {d1_frame, d1_line, d1_req}, 3'b111);
        chk("re_sxsy",   {d1_sx, d1_sy}, 0);
        step(FRAME - 1);
        chk("re_end_frame", d1_frame, 0);
        chk("re_end_sxsy",  {d1_sx, d1_sy}, {12'd63, 12'd22});
        step(1);
        chk("re_next_frame", d1_frame, 1);

        // asynchronous reset mid-line while a pixel is on the output
        step(807);
        chk("pre_rst_pix", {d1_de, d1_ch2, d1_ch1, d1_ch0}, {1'b1, 24'h250CA5});
        rst_n = 1'b0;
        #1;
        chk("arst_de_data", {d1_de, d1_ch2, d1_ch1, d1_ch0}, 0);
        chk("arst_sync",    {d1_hsync, d1_vsync, d1_c0}, 4'b1111);
        chk("arst_cnt",     {d1_sx, d1_sy, d1_req, d1_frame, d1_line}, 0);
        chk("arst_d4_de",   d4_de, 0);
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("rel_frame",    {d1_frame, d1_line, d1_req}, 3'b111);
        chk("rel_sxsy",     {d1_sx, d1_sy}, 0);
        step(1);
        chk("rel_de0",      d1_de, 0);
        step(1);
        chk("rel_de1",      {d1_de, d1_ch0}, {1'b1, 8'hA5});

        // whole-frame tallies from the first frame
        chk("frame_de_cnt", de_cnt, 768);
        chk("frame_hs_cnt", hs_cnt, 138);
        chk("frame_vs_cnt", vs_cnt, 128);
        chk("frame_fr_cnt", fr_cnt, 1);
        chk("frame_pix",    bad_pix, 0);
        chk("ctrl_words",   bad_ctrl, 0);
        chk("blank_data",   bad_blank, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
